exec_unit_mc: RTL and testbench
===============================

Name: exec_unit_mc

Overview:
Parametrised execute-stage unit for the 5-stage RISC core. It replaces the single-cycle combinational ALU with a pipelined unit that has:
- two-source operand forwarding (EX/MEM and MEM/WB);
- an extended op set, including an iterative multi-cycle multiply;
- a built-in EX/MEM result register;
- a ready/hold/flush handshake to the hazard unit.

It sits between the ID/EX register and the memory stage.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), localparam; shift-amount bits taken from operand B

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  ID/EX presents a valid instruction this cycle
alu_op  in  3  000 OR, 001 AND, 010 XOR, 011 ADD, 100 SUB, 101 SLL, 110 SRL, 111 MUL
alu_src  in  1  1: operand B = imm; 0: operand B = forwarded rs2
mem_write  in  1  instruction is a store; captured to ex_mem_write
rd1  in  WIDTH  register-file rs1 value
rd2  in  WIDTH  register-file rs2 value
imm  in  WIDTH  sign-extended immediate
fwd_a  in  2  00 rd1, 01 exmem_fwd, 10 memwb_fwd, 11 rd1
fwd_b  in  2  same encoding, selects forwarded rs2 value
exmem_fwd  in  WIDTH  forwarding value from EX/MEM stage
memwb_fwd  in  WIDTH  forwarding value from MEM/WB stage
hold  in  1  downstream stall: freeze all state
flush  in  1  kill output and abort any multiply in progress
in_ready  out  1  combinational: !busy && !hold
busy  out  1  registered: multiply in progress
ex_valid  out  1  registered: ex_result/ex_store_data valid this cycle
ex_result  out  WIDTH  registered ALU result
ex_store_data  out  WIDTH  registered forwarded rs2 value for stores
ex_mem_write  out  1  registered copy of mem_write
ex_zero  out  1  registered: ex_result == 0

Behaviour:
- **Reset.** rst=1 at an edge clears: ex_valid=0, busy=0, ex_result=0, ex_store_data=0, ex_mem_write=0, ex_zero=1, multiply counter and accumulators=0. Reset overrides flush and hold, including mid-multiply.
- **Operand selection (combinational).**
  - A = mux(fwd_a).
  - fwdB = mux(fwd_b).
  - B = alu_src ? imm : fwdB.
  - Store data is always fwdB, never imm.
- **Accept.** An instruction is accepted when in_valid && in_ready && !flush.
- **Single-cycle ops (000-110), latency 1.** On accept, the next edge loads:
  - ex_result ← op(A,B); ex_store_data ← fwdB; ex_mem_write ← mem_write; ex_valid ← 1.
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLL/SRL are logical and use B[SHW-1:0].
- **No accept.** If a cycle has no accept, no hold and no multiply completion: ex_valid ← 0. ex_result, ex_store_data and ex_zero keep their previous values.
- **MUL (111), iterative shift-add, one multiplier bit per cycle.**
  - Accept edge: capture A, B and fwdB; busy ← 1; counter ← WIDTH; ex_valid ← 0.
  - Each subsequent non-held edge: add the shifted multiplicand if the current multiplier bit is 1, then decrement the counter.
  - The edge that takes the counter to 0 also sets: ex_result ← low WIDTH bits of A*B; ex_valid ← 1; ex_mem_write ← captured mem_write; busy ← 0.
  - An accepted MUL therefore gives ex_valid exactly WIDTH+... cycles: WIDTH edges after the accept edge.
  - busy is high for WIDTH cycles and in_ready is low for those cycles.
  - in_valid is ignored while busy.
- **hold=1.** Every register keeps its value, including the multiply counter and ex_valid. No accept occurs.
- **flush=1 (no rst).** Next edge: ex_valid ← 0, busy ← 0, counter ← 0, ex_mem_write ← 0. The concurrent instruction is not accepted. flush beats hold.
- **Priority:** rst > flush > hold > multiply-progress/accept.
- **ex_zero** is updated on every edge that loads ex_result.

Test Plan:
- **Forwarding.** ADD, fwd_a=01, exmem_fwd=0x10, rd1=0x99; fwd_b=10, memwb_fwd=0x5; alu_src=0 → next cycle ex_result=0x15, ex_valid=1, ex_store_data=0x5.
- **Store data.** alu_src=1, imm=0x8, fwd_b=01, exmem_fwd=0xCAFE, mem_write=1, ADD with rd1=0x100 → ex_result=0x108, ex_store_data=0xCAFE, ex_mem_write=1.
- **Multiply latency and busy.** MUL A=7, B=0xFFFFFFFF → busy=1 and in_ready=0 for 32 cycles; ex_valid pulses 1 cycle with ex_result=0xFFFFFFF9. in_valid held 1 with OR during busy → no extra output.
- **Hold mid-multiply.** Issue MUL 3*5; assert hold for 4 cycles at count 10 → completion delayed by exactly 4 cycles; result=15. Also: SUB 0-1 → 0xFFFFFFFF, ex_zero=0; XOR 0xA5,0xA5 → 0, ex_zero=1.
- **Flush and reset mid-multiply.**
  - Flush at count 20 → next cycle busy=0, ex_valid=0, in_ready=1; a new ADD is accepted afterwards.
  - rst during busy → all outputs at reset values next cycle.
- **Shifts.** SLL A=1, B=0x25 → 0x20 (uses B[4:0]=5); SRL A=0x80000000, B=31 → 1.

Source files
------------

// File: rtl/exec_unit_mc_if.sv
// Execute-stage bundle: ID/EX instruction inputs, forwarding values, hazard-unit controls, EX/MEM outputs.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready && !flush; in_ready drops while busy or hold.
interface exec_unit_mc_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic [2:0]       alu_op;
   logic             alu_src;
   logic             mem_write;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] imm;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [WIDTH-1:0] exmem_fwd;
   logic [WIDTH-1:0] memwb_fwd;
   logic             hold;
   logic             flush;
   logic             in_ready;
   logic             busy;
   logic             ex_valid;
   logic [WIDTH-1:0] ex_result;
   logic [WIDTH-1:0] ex_store_data;
   logic             ex_mem_write;
   logic             ex_zero;

   modport master (
      output in_valid, alu_op, alu_src, mem_write, rd1, rd2, imm,
             fwd_a, fwd_b, exmem_fwd, memwb_fwd, hold, flush,
      input  in_ready, busy, ex_valid, ex_result, ex_store_data, ex_mem_write, ex_zero
   );

   modport slave (
      input  in_valid, alu_op, alu_src, mem_write, rd1, rd2, imm,
             fwd_a, fwd_b, exmem_fwd, memwb_fwd, hold, flush,
      output in_ready, busy, ex_valid, ex_result, ex_store_data, ex_mem_write, ex_zero
   );
endinterface

// File: rtl/exec_unit_mc.sv
// Pipelined execute stage: operand forwarding, single-cycle ALU ops, iterative shift-add multiply,
// and the EX/MEM result register with hold/flush control from the hazard unit.
module exec_unit_mc #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   exec_unit_mc_if.slave bus,
   output logic          dbg_state
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int CNT_W = SHW + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   localparam logic [2:0] OP_OR  = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;
   state_t state;

   logic [WIDTH-1:0] op_a, fwd_b_val, op_b, alu_y;
   logic [WIDTH-1:0] mul_acc, mul_cand, mul_plier, mul_sd, mul_sum;
   logic [CNT_W-1:0] mul_cnt;
   logic             mul_mw, mul_last, accept;

   always_comb begin
      case (bus.fwd_a)
         2'b01:   op_a = bus.exmem_fwd;
         2'b10:   op_a = bus.memwb_fwd;
         default: op_a = bus.rd1;
      endcase
      case (bus.fwd_b)
         2'b01:   fwd_b_val = bus.exmem_fwd;
         2'b10:   fwd_b_val = bus.memwb_fwd;
         default: fwd_b_val = bus.rd2;
      endcase
      op_b = bus.alu_src ? bus.imm : fwd_b_val;
      case (bus.alu_op)
         OP_OR:   alu_y = op_a | op_b;
         OP_AND:  alu_y = op_a & op_b;
         OP_XOR:  alu_y = op_a ^ op_b;
         OP_ADD:  alu_y = op_a + op_b;
         OP_SUB:  alu_y = op_a - op_b;
         OP_SLL:  alu_y = op_a << op_b[SHW-1:0];
         OP_SRL:  alu_y = op_a >> op_b[SHW-1:0];
         default: alu_y = '0;
      endcase
   end

   assign bus.in_ready = !bus.busy && !bus.hold;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
   // Multiplicand shifts left and multiplier shifts right, so bit 0 is always the current multiplier bit.
   assign mul_sum      = mul_acc + (mul_plier[0] ? mul_cand : '0);
   assign mul_last     = (mul_cnt == CNT_ONE);
   assign dbg_state    = (state == ST_MUL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         bus.busy          <= 1'b0;
         bus.ex_valid      <= 1'b0;
         bus.ex_result     <= '0;
         bus.ex_store_data <= '0;
         bus.ex_mem_write  <= 1'b0;
         bus.ex_zero       <= 1'b1;
         mul_cnt           <= '0;
         mul_acc           <= '0;
         mul_cand          <= '0;
         mul_plier         <= '0;
         mul_sd            <= '0;
         mul_mw            <= 1'b0;
      end else if (bus.flush) begin
         state            <= ST_IDLE;
         bus.busy         <= 1'b0;
         bus.ex_valid     <= 1'b0;
         bus.ex_mem_write <= 1'b0;
         mul_cnt          <= '0;
      end else if (!bus.hold) begin
         case (state)
            ST_MUL: begin
               mul_acc      <= mul_sum;
               mul_cand     <= mul_cand << 1;
               mul_plier    <= mul_plier >> 1;
               mul_cnt      <= mul_cnt - CNT_ONE;
               bus.ex_valid <= 1'b0;
               if (mul_last) begin
                  state             <= ST_IDLE;
                  bus.busy          <= 1'b0;
                  bus.ex_valid      <= 1'b1;
                  bus.ex_result     <= mul_sum;
                  bus.ex_zero       <= (mul_sum == '0);
                  bus.ex_store_data <= mul_sd;
                  bus.ex_mem_write  <= mul_mw;
               end
            end
            default: begin
               if (accept && bus.alu_op == OP_MUL) begin
                  state        <= ST_MUL;
                  bus.busy     <= 1'b1;
                  bus.ex_valid <= 1'b0;
                  mul_cnt      <= CNT_FULL;
                  mul_acc      <= '0;
                  mul_cand     <= op_a;
                  mul_plier    <= op_b;
                  mul_sd       <= fwd_b_val;
                  mul_mw       <= bus.mem_write;
               end else if (accept) begin
                  bus.ex_valid      <= 1'b1;
                  bus.ex_result     <= alu_y;
                  bus.ex_zero       <= (alu_y == '0);
                  bus.ex_store_data <= fwd_b_val;
                  bus.ex_mem_write  <= bus.mem_write;
               end else begin
                  bus.ex_valid <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed scenarios plus random traffic, checked by an expected-queue scoreboard.
module tb_exec_unit_mc;
   localparam int W  = 32;
   localparam int EW = 2 * W + 1;
   localparam logic [2:0] OR_OP = 3'b000, XOR_OP = 3'b010, ADD_OP = 3'b011, SUB_OP = 3'b100;
   localparam logic [2:0] SLL_OP = 3'b101, SRL_OP = 3'b110, MUL_OP = 3'b111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dbg_state;
   logic hold_en = 1'b0;
   logic last_held = 1'b0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int checks = 0;
   int failures = 0;

   exec_unit_mc_if #(.WIDTH(W)) bus();
   exec_unit_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] reg_v,
                                         input logic [W-1:0] ex_v, input logic [W-1:0] wb_v);
      if (sel == 2'b01) return ex_v;
      if (sel == 2'b10) return wb_v;
      return reg_v;
   endfunction

   function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      case (op)
         3'd0: return a | b;
         3'd1: return a & b;
         3'd2: return a ^ b;
         3'd3: return a + b;
         3'd4: return a - b;
         3'd5: return a << (b % W);
         3'd6: return a >> (b % W);
         default: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return p[W-1:0];
         end
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic src, input logic mw,
                        input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] im,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [W-1:0] ex, input logic [W-1:0] wb);
      logic [W-1:0] a, fbv, b;
      logic acc;
      int guard;
      a   = pick(fa, r1, ex, wb);
      fbv = pick(fb, r2, ex, wb);
      b   = src ? im : fbv;
      bus.in_valid = 1'b1; bus.alu_op = op; bus.alu_src = src; bus.mem_write = mw;
      bus.rd1 = r1; bus.rd2 = r2; bus.imm = im; bus.fwd_a = fa; bus.fwd_b = fb;
      bus.exmem_fwd = ex; bus.memwb_fwd = wb;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
         bus.hold = hold_en && ($urandom_range(0, 5) == 0);
         #1;
         acc = bus.in_ready;
         if (acc) exp_q.push_back({mw, fbv, ref_op(op, a, b)});
         @(posedge clk); #1;
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.hold = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL issue_timeout act=no_accept exp=accept_within_200_cycles");
      end else if (op == MUL_OP) begin
         chk("mul_start_busy", bus.busy, 1);
         chk("mul_start_ready", bus.in_ready, 0);
      end else begin
         chk("lat1_valid", bus.ex_valid, 1);
      end
   endtask

   // Monitor: a held edge leaves ex_valid up, so only outputs produced by a non-held edge are new.
   always @(posedge clk) last_held <= bus.hold && !bus.flush && !rst;

   always @(negedge clk) begin
      if (!rst && bus.ex_valid && !last_held) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output act=%h exp=none", bus.ex_result);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_result", bus.ex_result, mon_e[W-1:0]);
            chk("sb_store", bus.ex_store_data, mon_e[2*W-1:W]);
            chk("sb_mem_write", W'(bus.ex_mem_write), W'(mon_e[2*W]));
            chk("sb_zero", W'(bus.ex_zero), W'(mon_e[W-1:0] == '0));
         end
      end
   end

   initial begin
      int k;
      logic done;
      bus.in_valid = 0; bus.alu_op = 0; bus.alu_src = 0; bus.mem_write = 0;
      bus.rd1 = 0; bus.rd2 = 0; bus.imm = 0; bus.fwd_a = 0; bus.fwd_b = 0;
      bus.exmem_fwd = 0; bus.memwb_fwd = 0; bus.hold = 0; bus.flush = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.ex_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_result", bus.ex_result, 0);
      chk("rst_store", bus.ex_store_data, 0);
      chk("rst_mem_write", bus.ex_mem_write, 0);
      chk("rst_zero", bus.ex_zero, 1);
      rst = 1'b0;
      #1;
      chk("rst_ready", bus.in_ready, 1);

      // forwarding and store data
      issue(ADD_OP, 0, 0, 32'h99, 32'h0, 32'h0, 2'b01, 2'b10, 32'h10, 32'h5);
      chk("fwd_result", bus.ex_result, 32'h15);
      chk("fwd_store", bus.ex_store_data, 32'h5);
      issue(ADD_OP, 1, 1, 32'h100, 32'h0, 32'h8, 2'b00, 2'b01, 32'hCAFE, 32'h0);
      chk("st_result", bus.ex_result, 32'h108);
      chk("st_store", bus.ex_store_data, 32'hCAFE);
      chk("st_mem_write", bus.ex_mem_write, 1);

      // shifts, SUB wrap, XOR zero
      issue(SLL_OP, 1, 0, 32'h1, 32'h0, 32'h25, 2'b00, 2'b00, 32'h0, 32'h0);
      chk("sll_result", bus.ex_result, 32'h20);
      issue(SRL_OP, 1, 0, 32'h80000000, 32'h0, 32'd31, 2'b00, 2'b00, 32'h0, 32'h0);
      chk("srl_result", bus.ex_result, 32'h1);
      issue(SUB_OP, 1, 0, 32'h0, 32'h0, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0);
      chk("sub_result", bus.ex_result, 32'hFFFFFFFF);
      chk("sub_zero", bus.ex_zero, 0);
      issue(XOR_OP, 0, 0, 32'hA5, 32'hA5, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
      chk("xor_zero", bus.ex_zero, 1);

      // MUL latency with OR held on in_valid while busy
      issue(MUL_OP, 1, 0, 32'd7, 32'h0, 32'hFFFFFFFF, 2'b00, 2'b00, 32'h0, 32'h0);
      bus.in_valid = 1'b1; bus.alu_op = OR_OP; bus.alu_src = 0;
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (i < W) begin
            chk("mul_busy", bus.busy, 1);
            chk("mul_not_ready", bus.in_ready, 0);
            chk("mul_no_valid", bus.ex_valid, 0);
         end else begin
            chk("mul_done_busy", bus.busy, 0);
            chk("mul_done_valid", bus.ex_valid, 1);
            chk("mul_done_result", bus.ex_result, 32'hFFFFFFF9);
         end
         if (i == W - 1) bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("mul_single_pulse", bus.ex_valid, 0);

      // hold for 4 cycles when the counter reads 10
      issue(MUL_OP, 1, 1, 32'd3, 32'h0, 32'd5, 2'b00, 2'b00, 32'h0, 32'h0);
      k = 0;
      done = 1'b0;
      while (!done && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (k == 22) bus.hold = 1'b1;
         if (k == 26) bus.hold = 1'b0;
         if (bus.ex_valid) done = 1'b1;
      end
      chk("mul_hold_latency", k, 36);
      chk("mul_hold_result", bus.ex_result, 32'd15);

      // flush when the counter reads 20
      issue(MUL_OP, 0, 0, 32'd9, 32'd11, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
      repeat (12) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("flush_busy", bus.busy, 0);
      chk("flush_valid", bus.ex_valid, 0);
      chk("flush_ready", bus.in_ready, 1);
      chk("flush_mem_write", bus.ex_mem_write, 0);
      issue(ADD_OP, 1, 0, 32'd2, 32'h0, 32'd3, 2'b00, 2'b00, 32'h0, 32'h0);
      chk("post_flush_add", bus.ex_result, 32'd5);

      // reset mid-multiply overrides a concurrent hold
      issue(MUL_OP, 1, 1, 32'd6, 32'h77, 32'd7, 2'b00, 2'b00, 32'h0, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.hold = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_valid", bus.ex_valid, 0);
      chk("midrst_result", bus.ex_result, 0);
      chk("midrst_store", bus.ex_store_data, 0);
      chk("midrst_mem_write", bus.ex_mem_write, 0);
      chk("midrst_zero", bus.ex_zero, 1);
      rst = 1'b0;
      bus.hold = 1'b0;
      exp_q.delete();

      // random traffic with random hold bubbles
      hold_en = 1'b1;
      for (int n = 0; n < 150; n++) begin
         logic [W-1:0] r1, r2;
         r1 = $urandom();
         r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom();
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               r1, r2, $urandom(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               $urandom(), $urandom());
      end
      hold_en = 1'b0;

      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      @(posedge clk); #1;
      chk("drain_queue", W'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
